// File: rtl/framebuffer_readback_pkg.sv
// ---------------------------------------------------------------------------
// framebuffer_readback_pkg
// Framebuffer geometry and frame constants shared by control_module (which
// writes rows into port A) and framebuffer_readback (which reads them back).
// Contents:
//   ROW_WIDTH        - row-select width (32 rows)
//   BYTES_PER_ROW    - data bytes per row, a power of two
//   BYTE_INDEX_WIDTH - log2(BYTES_PER_ROW), low field of the port A address
//   FB_ADDR_WIDTH    - port A address width = {row, byte_index}
//   HEADER_BYTE      - ASCII 'L', first character of every readback frame
//   LAST_BYTE_INDEX  - byte index of the final data byte in a row
//   rowToByte()      - zero-extends a row number into the frame's row byte
// ---------------------------------------------------------------------------
package framebuffer_readback_pkg;

    localparam int unsigned ROW_WIDTH        = 5;
    localparam int unsigned BYTES_PER_ROW    = 128;
    localparam int unsigned BYTE_INDEX_WIDTH = $clog2(BYTES_PER_ROW);
    localparam int unsigned FB_ADDR_WIDTH    = 12;

    localparam logic [7:0] HEADER_BYTE = 8'h4C;

    localparam logic [BYTE_INDEX_WIDTH-1:0] LAST_BYTE_INDEX =
        BYTE_INDEX_WIDTH'(BYTES_PER_ROW - 1);

    // The row byte on the wire is the row number padded with zeros on top.
    function automatic logic [7:0] rowToByte(input logic [ROW_WIDTH-1:0] row);
        return {{(8 - ROW_WIDTH){1'b0}}, row};
    endfunction

endpackage

// File: rtl/framebuffer_readback_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Sends one 8N1 character: start bit 0, eight data bits LSB-first, stop bit 1,
// each bit held for exactly UART_TICKS_PER_BIT clock cycles.
// Ports:
//   clk_in   - system clock
//   reset    - synchronous, active-high; line returns high immediately
//   data     - byte to send, taken on an accepted load
//   load     - start a character; ignored while tx_busy is high
//   tx_out   - serial line, idles high
//   tx_busy  - high while a character is on the line
//   tx_done  - one-cycle pulse once the stop bit has been fully held
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int unsigned                         UART_TICKS_PER_BIT_WIDTH = 9,
    parameter logic [UART_TICKS_PER_BIT_WIDTH-1:0] UART_TICKS_PER_BIT       = 9'd434
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [UART_TICKS_PER_BIT_WIDTH-1:0] LAST_TICK =
        UART_TICKS_PER_BIT_WIDTH'(UART_TICKS_PER_BIT - 1);

    logic [9:0]                          frame_q;
    logic [3:0]                          bitCount_q;
    logic [UART_TICKS_PER_BIT_WIDTH-1:0] tickCount_q;
    logic                                busy_q;
    logic                                done_q;

    // The whole character (stop, data, start) sits in one shift register and
    // the line is always its LSB. Ones are shifted in from the top, so after
    // the stop bit the line simply stays high with no extra idle logic.
    // Bit index 9 is the stop bit; when its last tick expires the character
    // is complete and tx_done pulses for a single cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_q     <= '1;
            bitCount_q  <= '0;
            tickCount_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (load) begin
                    frame_q     <= {1'b1, data, 1'b0};
                    bitCount_q  <= '0;
                    tickCount_q <= '0;
                    busy_q      <= 1'b1;
                end
            end else if (tickCount_q == LAST_TICK) begin
                tickCount_q <= '0;
                if (bitCount_q == 4'd9) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    frame_q    <= {1'b1, frame_q[9:1]};
                    bitCount_q <= bitCount_q + 4'd1;
                end
            end else begin
                tickCount_q <= tickCount_q + 1'b1;
            end
        end
    end

    assign tx_out  = frame_q[0];
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: rtl/framebuffer_readback.sv
// ---------------------------------------------------------------------------
// framebuffer_readback
// Reads one 128-byte framebuffer row through port A and streams it out as a
// UART frame: header 'L', the row number, then the 128 data bytes in order.
// Ports:
//   clk_in         - system clock (shared with control_module)
//   reset          - synchronous, active-high; aborts any frame in progress
//   start          - one-cycle request, only honoured when idle
//   row_select     - row to dump, latched when start is accepted
//   ram_address    - port A address {row, byte_index}
//   ram_clk_enable - port A read strobe, one cycle per data byte
//   ram_data_in    - port A read data, valid one cycle after the strobe
//   tx_out         - UART line, idles high
//   busy           - high from the cycle after an accepted start until done
//   done           - one-cycle pulse after the final stop bit
// ---------------------------------------------------------------------------
module framebuffer_readback
    import framebuffer_readback_pkg::*;
#(
    parameter int unsigned                         UART_TICKS_PER_BIT_WIDTH = 9,
    parameter logic [UART_TICKS_PER_BIT_WIDTH-1:0] UART_TICKS_PER_BIT       = 9'd434
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_WIDTH-1:0]     row_select,
    output logic [FB_ADDR_WIDTH-1:0] ram_address,
    output logic                     ram_clk_enable,
    input  logic [7:0]               ram_data_in,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ROW,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_e;

    state_e                      state_q;
    state_e                      return_q;
    logic [ROW_WIDTH-1:0]        row_q;
    logic [BYTE_INDEX_WIDTH-1:0] byteIndex_q;
    logic                        dataSent_q;
    logic [7:0]                  fetched_q;
    logic [FB_ADDR_WIDTH-1:0]    ramAddress_q;
    logic                        ramEnable_q;
    logic                        busy_q;
    logic                        done_q;

    logic [BYTE_INDEX_WIDTH-1:0] nextIndex_d;
    logic                        txLoad;
    logic [7:0]                  txData;
    logic                        txBusy;
    logic                        txDone;

    // The row byte is followed by data byte 0, and every data byte by the
    // next one; dataSent_q tells those two cases apart when leaving SEND.
    assign nextIndex_d = dataSent_q ? byteIndex_q + 1'b1 : byteIndex_q;

    // The transmitter is loaded straight from the state so a character starts
    // on the very next edge, which keeps the inter-byte gap within 4 cycles.
    always_comb begin
        txLoad = 1'b0;
        txData = fetched_q;
        unique case (state_q)
            S_HDR: begin
                txLoad = 1'b1;
                txData = HEADER_BYTE;
            end
            S_ROW: begin
                txLoad = 1'b1;
                txData = rowToByte(row_q);
            end
            S_LOAD: begin
                txLoad = 1'b1;
            end
            default: begin
                txLoad = 1'b0;
            end
        endcase
    end

    // Frame sequencer. SEND always waits for the character to finish and then
    // jumps to return_q. The RAM strobe and address are set on the edge into
    // FETCH so the strobe is high for that single cycle only, leaving port A
    // free for the arbiter everywhere else. The read data is captured at the
    // end of WAIT, the one cycle it is guaranteed valid, and handed to the
    // transmitter in LOAD.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= S_IDLE;
            return_q     <= S_IDLE;
            row_q        <= '0;
            byteIndex_q  <= '0;
            dataSent_q   <= 1'b0;
            fetched_q    <= '0;
            ramAddress_q <= '0;
            ramEnable_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ramEnable_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q       <= row_select;
                        byteIndex_q <= '0;
                        dataSent_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_HDR;
                    end
                end
                S_HDR: begin
                    return_q <= S_ROW;
                    state_q  <= S_SEND;
                end
                S_ROW: begin
                    return_q <= S_FETCH;
                    state_q  <= S_SEND;
                end
                S_FETCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    fetched_q <= ram_data_in;
                    state_q   <= S_LOAD;
                end
                S_LOAD: begin
                    dataSent_q <= 1'b1;
                    return_q   <= (byteIndex_q == LAST_BYTE_INDEX) ? S_DONE : S_FETCH;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (txDone && !txBusy) begin
                        if (return_q == S_DONE) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (return_q == S_FETCH) begin
                            byteIndex_q  <= nextIndex_d;
                            ramAddress_q <= {row_q, nextIndex_d};
                            ramEnable_q  <= 1'b1;
                            state_q      <= S_FETCH;
                        end else begin
                            state_q <= return_q;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .UART_TICKS_PER_BIT_WIDTH(UART_TICKS_PER_BIT_WIDTH),
        .UART_TICKS_PER_BIT      (UART_TICKS_PER_BIT)
    ) u_tx (
        .clk_in (clk_in),
        .reset  (reset),
        .data   (txData),
        .load   (txLoad),
        .tx_out (tx_out),
        .tx_busy(txBusy),
        .tx_done(txDone)
    );

    assign ram_address    = ramAddress_q;
    assign ram_clk_enable = ramEnable_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_framebuffer_readback.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_readback
// Drives framebuffer_readback with a 4-tick UART and a behavioural port A RAM.
// A line monitor decodes every character and keeps its raw per-cycle samples;
// each frame is compared against the expected byte list built from the RAM
// contents ('L', row, mem[{row,i}]) and the ideal 8N1 waveform of each byte.
// ---------------------------------------------------------------------------
module tb_framebuffer_readback;

    localparam int TICKS    = 4;
    localparam int CHAR_CYC = 10 * TICKS;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  row_select = '0;
    logic [11:0] ram_address;
    logic        ram_clk_enable;
    logic [7:0]  ram_data_in = '0;
    logic        tx_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  mem [0:4095];

    logic [7:0]  rxByte[$];
    int          rxStart[$];
    logic        rxBusy[$];
    logic [39:0] rxSamples[$];
    logic [11:0] addrQ[$];
    int          doneCycQ[$];

    logic [39:0] monSamples;
    logic [7:0]  monByte;
    int          monStart;
    logic        monBusy;
    bit          monAbort;

    framebuffer_readback #(
        .UART_TICKS_PER_BIT_WIDTH(9),
        .UART_TICKS_PER_BIT      (9'd4)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .start         (start),
        .row_select    (row_select),
        .ram_address   (ram_address),
        .ram_clk_enable(ram_clk_enable),
        .ram_data_in   (ram_data_in),
        .tx_out        (tx_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Port A model: registered read, data appears one cycle after the strobe.
    always @(posedge clk_in) begin
        if (ram_clk_enable) ram_data_in <= mem[ram_address];
    end

    always @(negedge clk_in) begin
        if (ram_clk_enable) addrQ.push_back(ram_address);
        if (done) doneCycQ.push_back(cyc);
    end

    // Line monitor: one sample per cycle for a whole character, decoded at
    // mid-bit. A character overlapped by reset is discarded.
    initial begin : charMonitor
        forever begin
            @(negedge clk_in);
            if (!reset && tx_out === 1'b0) begin
                monStart   = cyc;
                monBusy    = busy;
                monAbort   = 1'b0;
                monSamples = '0;
                for (int i = 1; i < CHAR_CYC; i++) begin
                    @(negedge clk_in);
                    if (reset) monAbort = 1'b1;
                    monSamples[i] = tx_out;
                end
                if (!monAbort) begin
                    for (int k = 0; k < 8; k++) monByte[k] = monSamples[TICKS * (k + 1) + TICKS / 2];
                    rxByte.push_back(monByte);
                    rxStart.push_back(monStart);
                    rxBusy.push_back(monBusy);
                    rxSamples.push_back(monSamples);
                end
            end
        end
    end

    initial begin : watchdog
        #(10 * 90000);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [39:0] charPattern(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] p;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < TICKS; j++) p[k * TICKS + j] = bits[k];
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] row);
        @(negedge clk_in);
        row_select = row;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        row_select = 5'($urandom);
    endtask

    task automatic clearCapture();
        rxByte.delete();
        rxStart.delete();
        rxBusy.delete();
        rxSamples.delete();
        addrQ.delete();
        doneCycQ.delete();
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 8000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput({tag, " done seen"}, 32'(done), 32'd1);
        checkOutput({tag, " busy low on done"}, 32'(busy), 32'd0);
    endtask

    // Compares one captured frame against the model built from the RAM image.
    task automatic checkFrame(input string tag, input logic [4:0] row, input int chOff,
                              input int adOff, input int doneIdx);
        logic [7:0]  expByte;
        logic [11:0] expAddr;
        int byteErr = 0, waveErr = 0, busyErr = 0, gapErr = 0, addrErr = 0;
        int gap, frameLen;
        checkOutput({tag, " chars"}, 32'(rxByte.size() >= chOff + 130), 32'd1);
        for (int i = 0; i < 130; i++) begin
            if (i == 0) expByte = 8'h4C;
            else if (i == 1) expByte = {3'b000, row};
            else expByte = mem[{row, 7'(i - 2)}];
            if (chOff + i >= rxByte.size()) begin
                byteErr++;
                continue;
            end
            if (rxByte[chOff + i] !== expByte) byteErr++;
            if (rxSamples[chOff + i] !== charPattern(expByte)) waveErr++;
            if (rxBusy[chOff + i] !== 1'b1) busyErr++;
            if (i > 0) begin
                gap = rxStart[chOff + i] - rxStart[chOff + i - 1] - CHAR_CYC;
                if (gap < 0 || gap > 4) gapErr++;
            end
        end
        checkOutput({tag, " byte errors"}, 32'(byteErr), 32'd0);
        checkOutput({tag, " waveform errors"}, 32'(waveErr), 32'd0);
        checkOutput({tag, " busy errors"}, 32'(busyErr), 32'd0);
        checkOutput({tag, " gap errors"}, 32'(gapErr), 32'd0);
        checkOutput({tag, " reads"}, 32'(addrQ.size() >= adOff + 128), 32'd1);
        for (int i = 0; i < 128; i++) begin
            expAddr = {row, 7'(i)};
            if (adOff + i >= addrQ.size() || addrQ[adOff + i] !== expAddr) addrErr++;
        end
        checkOutput({tag, " address errors"}, 32'(addrErr), 32'd0);
        if (doneIdx < doneCycQ.size() && chOff < rxStart.size())
            frameLen = doneCycQ[doneIdx] - rxStart[chOff];
        else
            frameLen = -1;
        checkOutput({tag, " frame length in range"}, 32'(frameLen >= 5200 && frameLen <= 5720), 32'd1);
    endtask

    initial begin : stimulus
        int n;
        logic [4:0] randRow;

        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);

        // Reset state.
        repeat (3) @(negedge clk_in);
        checkOutput("reset tx_out", 32'(tx_out), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset ram_clk_enable", 32'(ram_clk_enable), 32'd0);
        checkOutput("reset ram_address", 32'(ram_address), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // Basic frame, row 0, identity RAM image.
        $display("[TB] basic frame row 0");
        clearCapture();
        applyStimulus(5'd0);
        checkOutput("basic busy after start", 32'(busy), 32'd1);
        waitDone("basic");
        repeat (3) @(negedge clk_in);
        checkFrame("basic", 5'd0, 0, 0, 0);
        checkOutput("basic header waveform", rxSamples[0][31:0], 32'hF00FF000);
        checkOutput("basic header waveform top", 32'(rxSamples[0][39:32]), 32'hF0);
        checkOutput("basic done pulses", 32'(doneCycQ.size()), 32'd1);

        // Top row: addresses 0xF80..0xFFF.
        $display("[TB] top row 31");
        clearCapture();
        applyStimulus(5'd31);
        waitDone("top");
        repeat (3) @(negedge clk_in);
        checkFrame("top", 5'd31, 0, 0, 0);
        checkOutput("top read count", 32'(addrQ.size()), 32'd128);
        checkOutput("top first address", 32'(addrQ[0]), 32'hF80);
        checkOutput("top last address", 32'(addrQ[127]), 32'hFFF);

        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);

        // Busy guard and start on the DONE cycle.
        $display("[TB] busy guard");
        clearCapture();
        applyStimulus(5'd3);
        repeat (100) @(negedge clk_in);
        applyStimulus(5'd9);
        waitDone("guard");
        start = 1'b1;
        row_select = 5'd7;
        @(negedge clk_in);
        start = 1'b0;
        repeat (200) @(negedge clk_in);
        checkOutput("guard idle busy", 32'(busy), 32'd0);
        checkOutput("guard char count", 32'(rxByte.size()), 32'd130);
        checkOutput("guard read count", 32'(addrQ.size()), 32'd128);
        checkOutput("guard done pulses", 32'(doneCycQ.size()), 32'd1);
        checkFrame("guard", 5'd3, 0, 0, 0);

        // Reset asserted together with start.
        $display("[TB] reset with start");
        clearCapture();
        @(negedge clk_in);
        reset = 1'b1;
        start = 1'b1;
        row_select = 5'd1;
        @(negedge clk_in);
        reset = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk_in);
        checkOutput("reset-start busy", 32'(busy), 32'd0);
        checkOutput("reset-start reads", 32'(addrQ.size()), 32'd0);

        // Reset in the middle of data byte 40.
        $display("[TB] reset mid-frame");
        clearCapture();
        applyStimulus(5'd6);
        n = 0;
        while (rxByte.size() < 42 && n < 4000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("abort progress", 32'(rxByte.size() >= 42), 32'd1);
        repeat (10) @(negedge clk_in);
        checkOutput("abort busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk_in);
        checkOutput("abort tx_out", 32'(tx_out), 32'd1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ram_clk_enable", 32'(ram_clk_enable), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk_in);
        checkOutput("abort no done", 32'(doneCycQ.size()), 32'd0);
        checkOutput("abort line idle", 32'(tx_out), 32'd1);

        clearCapture();
        applyStimulus(5'd5);
        waitDone("after abort");
        repeat (3) @(negedge clk_in);
        checkFrame("after abort", 5'd5, 0, 0, 0);

        // Random row.
        randRow = 5'($urandom_range(0, 31));
        $display("[TB] random row %0d", randRow);
        clearCapture();
        applyStimulus(randRow);
        waitDone("random");
        repeat (3) @(negedge clk_in);
        checkFrame("random", randRow, 0, 0, 0);

        // Back-to-back frames, second start on the first IDLE cycle.
        $display("[TB] back-to-back row 2");
        clearCapture();
        applyStimulus(5'd2);
        waitDone("b2b first");
        @(negedge clk_in);
        row_select = 5'd2;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        checkOutput("b2b second accepted", 32'(busy), 32'd1);
        waitDone("b2b second");
        repeat (3) @(negedge clk_in);
        checkFrame("b2b first", 5'd2, 0, 0, 0);
        checkFrame("b2b second", 5'd2, 130, 128, 1);
        checkOutput("b2b done pulses", 32'(doneCycQ.size()), 32'd2);
        checkOutput("b2b contiguous",
                    32'(rxStart.size() > 130 && doneCycQ.size() > 0 &&
                        rxStart[130] - doneCycQ[0] <= 8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
